// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit processor control path.
// State encoding, opcode map and ALU operation codes.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_START      = 3'd0,
    ST_FETCH_OP   = 3'd1,
    ST_FETCH_ADDR = 3'd2,
    ST_DISPATCH   = 3'd3,
    ST_EXEC_MEM   = 3'd4,
    ST_HALT       = 3'd5
  } state_t;

  typedef logic [3:0] opcode_t;
  typedef logic [1:0] alu_op_t;

  localparam opcode_t OP_NOP   = 4'h0;
  localparam opcode_t OP_LOAD  = 4'h1;
  localparam opcode_t OP_STORE = 4'h2;
  localparam opcode_t OP_ADD   = 4'h3;
  localparam opcode_t OP_SUB   = 4'h4;
  localparam opcode_t OP_JMP   = 4'h5;
  localparam opcode_t OP_JZ    = 4'h6;
  localparam opcode_t OP_HALT  = 4'hF;

  localparam alu_op_t ALU_PASS = 2'b00;
  localparam alu_op_t ALU_ADD  = 2'b01;
  localparam alu_op_t ALU_SUB  = 2'b10;

  function automatic logic is_mem_op(
    input opcode_t op
  );
    return (op == OP_LOAD) || (op == OP_STORE)
        || (op == OP_ADD)  || (op == OP_SUB);
  endfunction

  function automatic alu_op_t alu_of(
    input opcode_t op
  );
    alu_op_t r;
    unique case (op)
      OP_ADD:  r = ALU_ADD;
      OP_SUB:  r = ALU_SUB;
      default: r = ALU_PASS;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: owns pc and the two-byte instruction
// register and drives the memory handshake and datapath strobes.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_rdy,
  input  logic [7:0] mem_rdata,
  input  logic       zero_flag,
  output logic       fetch,
  output logic [7:0] pc,
  output logic [7:0] irh,
  output logic [7:0] irl,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       acc_ld,
  output logic [1:0] alu_op,
  output logic       halted
);

  state_t     r_state;
  logic [7:0] r_pc;
  logic [7:0] r_irh;
  logic [7:0] r_irl;

  opcode_t w_op;
  logic    w_is_mem;
  logic    w_is_store;
  logic    w_is_jmp;
  logic    w_is_jz;
  logic    w_is_halt;

  assign w_op       = r_irh[7:4];
  assign w_is_mem   = is_mem_op(w_op);
  assign w_is_store = (w_op == OP_STORE);
  assign w_is_jmp   = (w_op == OP_JMP);
  assign w_is_jz    = (w_op == OP_JZ);
  assign w_is_halt  = (w_op == OP_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_START;
      r_pc    <= RESET_PC;
      r_irh   <= 8'h00;
      r_irl   <= 8'h00;
    end else begin
      unique case (r_state)
        ST_START: begin
          r_state <= ST_FETCH_OP;
        end
        ST_FETCH_OP: begin
          if (mem_rdy) begin
            r_irh   <= mem_rdata;
            r_pc    <= r_pc + 8'd1;
            r_state <= ST_FETCH_ADDR;
          end
        end
        ST_FETCH_ADDR: begin
          if (mem_rdy) begin
            r_irl   <= mem_rdata;
            r_pc    <= r_pc + 8'd1;
            r_state <= ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          unique case (1'b1)
            w_is_mem: begin
              r_state <= ST_EXEC_MEM;
            end
            w_is_jmp: begin
              r_pc    <= r_irl;
              r_state <= ST_FETCH_OP;
            end
            w_is_jz: begin
              if (zero_flag) r_pc <= r_irl;
              r_state <= ST_FETCH_OP;
            end
            w_is_halt: begin
              r_state <= ST_HALT;
            end
            default: begin
              r_state <= ST_FETCH_OP;
            end
          endcase
        end
        ST_EXEC_MEM: begin
          if (mem_rdy) r_state <= ST_FETCH_OP;
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_START;
        end
      endcase
    end
  end

  // Strobes decode from the registered state so they hold until mem_rdy.
  always_comb begin
    fetch  = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    alu_op = ALU_PASS;
    halted = 1'b0;
    unique case (r_state)
      ST_FETCH_OP, ST_FETCH_ADDR: begin
        fetch  = 1'b1;
        mem_rd = 1'b1;
      end
      ST_EXEC_MEM: begin
        mem_wr = w_is_store;
        mem_rd = !w_is_store;
        alu_op = alu_of(w_op);
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        fetch = 1'b0;
      end
    endcase
  end

  assign acc_ld = (r_state == ST_EXEC_MEM) && mem_rdy
               && w_is_mem && !w_is_store;

  assign pc  = r_pc;
  assign irh = r_irh;
  assign irl = r_irl;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a memory model with wait states,
// an expected-transaction queue and a bus monitor, plus a pc-wrap instance.
module tb_fetch_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       mem_rdy = 1'b0;
  logic [7:0] mem_rdata;
  logic       zero_flag;
  logic       fetch;
  logic [7:0] pc, irh, irl;
  logic       mem_rd, mem_wr, acc_ld;
  logic [1:0] alu_op;
  logic       halted;

  logic       rst_n_b;
  logic [7:0] mem_rdata_b;
  logic       fetch_b;
  logic [7:0] pc_b, irh_b, irl_b;
  logic       mem_rd_b, mem_wr_b, acc_ld_b;
  logic [1:0] alu_op_b;
  logic       halted_b;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];

  assign mem_rdata   = mem_a[fetch ? pc : irl];
  assign mem_rdata_b = mem_b[fetch_b ? pc_b : irl_b];

  fetch_sequencer #(.RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rdy(mem_rdy),
    .mem_rdata(mem_rdata), .zero_flag(zero_flag),
    .fetch(fetch), .pc(pc), .irh(irh), .irl(irl),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .acc_ld(acc_ld),
    .alu_op(alu_op), .halted(halted)
  );

  fetch_sequencer #(.RESET_PC(8'hFE)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .mem_rdy(1'b1),
    .mem_rdata(mem_rdata_b), .zero_flag(1'b0),
    .fetch(fetch_b), .pc(pc_b), .irh(irh_b), .irl(irl_b),
    .mem_rd(mem_rd_b), .mem_wr(mem_wr_b), .acc_ld(acc_ld_b),
    .alu_op(alu_op_b), .halted(halted_b)
  );

  typedef struct packed {
    logic       wr;
    logic       fch;
    logic [7:0] addr;
    logic [1:0] alu;
    logic       acc;
  } txn_t;

  txn_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   phase = 0;
  bit   mon_en = 1'b1;

  function automatic int waits(input int ph, input int n);
    if (ph == 0 && n == 0)  return 3;
    if (ph == 0 && n == 12) return 2;
    if (ph == 1 && n == 2)  return 10;
    return 0;
  endfunction

  // memory model: counts completed accesses, inserts wait states
  int acc_n = 0;
  int wcnt = 0;
  bit done = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_n = 0; wcnt = 0; done = 1'b0; mem_rdy = 1'b0;
    end else begin
      if (done) begin acc_n++; wcnt = 0; end
      if (mem_rd || mem_wr) begin
        if (wcnt < waits(phase, acc_n)) begin
          mem_rdy = 1'b0; wcnt++;
        end else mem_rdy = 1'b1;
      end else mem_rdy = 1'b1;
      done = mem_rdy && (mem_rd || mem_wr);
    end
  end

  // monitor: every completed bus transfer is matched against the queue
  always @(negedge clk) begin
    txn_t got, e;
    #1;
    if (rst_n && mon_en && mem_rdy && (mem_rd || mem_wr)) begin
      got.wr   = mem_wr;
      got.fch  = fetch;
      got.addr = fetch ? pc : irl;
      got.alu  = alu_op;
      got.acc  = acc_ld;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL txn unexpected got=%h", got);
      end else begin
        e = exp_q.pop_front();
        if (got === e && !(mem_rd && mem_wr)) n_pass++;
        else $display("FAIL txn got=%h exp=%h rd=%b wr=%b",
                      got, e, mem_rd, mem_wr);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  task automatic push_f(input logic [7:0] a);
    exp_q.push_back('{wr:1'b0, fch:1'b1, addr:a, alu:2'b00, acc:1'b0});
  endtask

  task automatic push_x(input logic w, input logic [7:0] a,
                        input logic [1:0] op, input logic ac);
    exp_q.push_back('{wr:w, fch:1'b0, addr:a, alu:op, acc:ac});
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #2;
  endtask

  initial begin
    int k;
    bit ok;
    int bad;
    rst_n = 1'b0; rst_n_b = 1'b0; zero_flag = 1'b1;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'h00; mem_b[i] = 8'h00;
    end
    mem_a[8'h00] = 8'h10; mem_a[8'h01] = 8'h80;
    mem_a[8'h02] = 8'h30; mem_a[8'h03] = 8'h81;
    mem_a[8'h04] = 8'h60; mem_a[8'h05] = 8'h20;
    mem_a[8'h20] = 8'h60; mem_a[8'h21] = 8'h30;
    mem_a[8'h22] = 8'h20; mem_a[8'h23] = 8'h40;
    mem_a[8'h26] = 8'h40; mem_a[8'h27] = 8'h82;
    mem_a[8'h28] = 8'h50; mem_a[8'h29] = 8'h30;
    mem_a[8'h30] = 8'hF0; mem_a[8'h31] = 8'h00;
    mem_a[8'h80] = 8'hAA; mem_a[8'h81] = 8'h01;
    mem_a[8'h82] = 8'h02;
    mem_b[8'hFE] = 8'h50; mem_b[8'hFF] = 8'h10;
    mem_b[8'h10] = 8'hF0;

    push_f(8'h00); push_f(8'h01); push_x(1'b0, 8'h80, ALU_PASS, 1'b1);
    push_f(8'h02); push_f(8'h03); push_x(1'b0, 8'h81, ALU_ADD, 1'b1);
    push_f(8'h04); push_f(8'h05);
    push_f(8'h20); push_f(8'h21);
    push_f(8'h22); push_f(8'h23); push_x(1'b1, 8'h40, ALU_PASS, 1'b0);
    push_f(8'h24); push_f(8'h25);
    push_f(8'h26); push_f(8'h27); push_x(1'b0, 8'h82, ALU_SUB, 1'b1);
    push_f(8'h28); push_f(8'h29);
    push_f(8'h30); push_f(8'h31);

    repeat (3) @(negedge clk);
    #1;
    chk("reset strobes",
        {26'd0, fetch, mem_rd, mem_wr, acc_ld, alu_op, halted}, 32'd0);
    chk("reset pc/ir", {8'd0, pc, irh, irl}, 32'd0);
    chk("reset pc_b", {24'd0, pc_b}, 32'h0000_00FE);
    #1 rst_n = 1'b1;
    chk("start fetch", {31'd0, fetch}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      step();
      chk("wait fetch_op", {fetch, mem_rd, pc, irh}, {2'b11, 16'h0000});
    end
    step();
    chk("irh load", {fetch, pc, irh}, {1'b1, 8'h01, 8'h10});
    step();
    chk("dispatch", {fetch, mem_rd, pc, irl}, {2'b00, 8'h02, 8'h80});
    step();
    chk("exec load", {fetch, mem_rd, mem_wr, alu_op},
        {3'b010, ALU_PASS});

    ok = 1'b0;
    for (k = 0; k < 100 && !ok; k++) begin
      step();
      if (pc == 8'h20) ok = 1'b1;
    end
    chk("jz taken seen", {31'd0, ok}, 32'd1);
    chk("jz taken ir", {irh, irl}, 16'h6020);
    zero_flag = 1'b0;

    ok = 1'b0;
    for (k = 0; k < 100 && !ok; k++) begin
      step();
      if (mem_wr) ok = 1'b1;
    end
    chk("store seen", {31'd0, ok}, 32'd1);
    chk("jz not taken", {pc, irl}, 16'h2440);
    chk("store strobes", {fetch, mem_rd, acc_ld}, 3'b000);

    ok = 1'b0;
    for (k = 0; k < 200 && !ok; k++) begin
      step();
      if (halted) ok = 1'b1;
    end
    chk("halt seen", {31'd0, ok}, 32'd1);
    chk("halt regs", {pc, irh, irl}, 24'h32F000);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mem_rd || mem_wr || fetch || !halted) bad++;
    end
    chk("halt quiet", bad, 32'd0);
    chk("queue drained p0", exp_q.size(), 32'd0);

    at_neg();
    rst_n_b = 1'b1;
    step();
    chk("wrap fetch_op", {fetch_b, pc_b}, {1'b1, 8'hFE});
    step();
    chk("wrap ff", {pc_b, irh_b}, 16'hFF50);
    step();
    chk("wrap 00", {fetch_b, pc_b, irl_b}, {1'b0, 8'h00, 8'h10});
    step();
    chk("wrap jmp", {fetch_b, pc_b}, {1'b1, 8'h10});

    phase = 1;
    at_neg();
    rst_n = 1'b0;
    #1 chk("halt cleared", {31'd0, halted}, 32'd0);
    push_f(8'h00); push_f(8'h01);
    at_neg();
    rst_n = 1'b1;
    ok = 1'b0;
    for (k = 0; k < 20 && !ok; k++) begin
      step();
      if (mem_rd && !fetch) ok = 1'b1;
    end
    chk("exec reached", {31'd0, ok}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset strobes",
        {26'd0, fetch, mem_rd, mem_wr, acc_ld, alu_op, halted}, 32'd0);
    chk("mid reset regs", {8'd0, pc, irh, irl}, 32'd0);
    chk("queue drained p1", exp_q.size(), 32'd0);

    phase = 2;
    push_f(8'h00); push_f(8'h01); push_x(1'b0, 8'h80, ALU_PASS, 1'b1);
    at_neg();
    rst_n = 1'b1;
    step();
    chk("restart", {fetch, mem_rd, pc}, {2'b11, 8'h00});
    ok = 1'b0;
    for (k = 0; k < 30 && !ok; k++) begin
      step();
      if (exp_q.size() == 0) ok = 1'b1;
    end
    chk("queue drained p2", {31'd0, ok}, 32'd1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    rst_n_b = 1'b0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
